// File: rtl/cmos_rx_pkg.sv
// Shared types and constants for the CMOS DVP receiver.
//   pix_mode_e    : latched pixel format (RAW8 / RGB565 / RGB888 / YUV422)
//   rx_state_e    : frame-level capture state
//   BPP_LUT       : bytes per output pixel, 2 bits per mode, indexed by mode
//   bytes_per_px(): lookup helper over BPP_LUT
package cmos_rx_pkg;

  typedef enum logic [1:0] {
    MODE_RAW8   = 2'd0,
    MODE_RGB565 = 2'd1,
    MODE_RGB888 = 2'd2,
    MODE_YUV422 = 2'd3
  } pix_mode_e;

  typedef enum logic [1:0] {
    ST_SKIP   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_ACTIVE = 2'd2
  } rx_state_e;

  // {YUV422, RGB888, RGB565, RAW8}
  localparam logic [7:0] BPP_LUT = {2'd2, 2'd3, 2'd2, 2'd1};

  function automatic logic [1:0] bytes_per_px(input pix_mode_e m);
    return BPP_LUT[{m, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/cmos_rx_pix_pack.sv
// Byte assembly and format expansion.
//   cmos_pclk_i, rstn_i : clock / synchronous active-low reset
//   clr_i               : drop any partially assembled pixel
//   byte_en_i, byte_i   : incoming byte and its qualifier
//   phase_i             : position of byte_i within the pixel
//   mode_i, swap_i      : latched format and byte-order selection
//   rgb_o, valid_o      : expanded pixel, valid with the final byte (combinational)
module cmos_rx_pix_pack
  import cmos_rx_pkg::*;
(
  input  logic        cmos_pclk_i,
  input  logic        rstn_i,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  phase_i,
  input  pix_mode_e   mode_i,
  input  logic        swap_i,
  output logic [23:0] rgb_o,
  output logic        valid_o
);

  logic [7:0]  b0;
  logic [7:0]  b1;
  logic [15:0] w565;

  always_ff @(posedge cmos_pclk_i) begin
    if (!rstn_i || clr_i) begin
      b0 <= '0;
      b1 <= '0;
    end else if (byte_en_i) begin
      if (phase_i == 2'd0) b0 <= byte_i;
      if (phase_i == 2'd1) b1 <= byte_i;
    end
  end

  // The final byte is used straight from the input so the pixel is
  // available in the same cycle it completes.
  always_comb begin
    valid_o = byte_en_i && (phase_i == bytes_per_px(mode_i) - 2'd1);
    w565    = swap_i ? {byte_i, b0} : {b0, byte_i};
    rgb_o   = '0;
    unique case (mode_i)
      MODE_RAW8:   rgb_o = {byte_i, byte_i, byte_i};
      MODE_RGB565: rgb_o = {w565[15:11], w565[15:13], w565[10:5], w565[10:9],
                            w565[4:0], w565[4:2]};
      MODE_RGB888: rgb_o = swap_i ? {byte_i, b1, b0} : {b0, b1, byte_i};
      MODE_YUV422: rgb_o = swap_i ? {byte_i, b0, 8'h00} : {b0, byte_i, 8'h00};
    endcase
  end

endmodule

// File: rtl/cmos_dvp_rx.sv
// CMOS DVP camera receiver.
//   cmos_pclk_i, rstn_i            : pixel clock / synchronous active-low reset
//   cmos_href_i, cmos_vsync_i      : line valid / frame sync
//   cmos_data_i                    : sensor data, byte is the top 8 bits
//   mode_i, swap_i, capture_en_i   : format, byte order, capture enable (latched per frame)
//   rgb_o, de_o, vs_o, hs_o        : pixel stream out
//   x_o, y_o, width_o              : pixel coordinates and first-line width
//   frame_cnt_o, line_err_o        : captured-frame count, line error pulse
module cmos_dvp_rx
  import cmos_rx_pkg::*;
#(
  parameter int DW         = 8,
  parameter int FRAME_SKIP = 5,
  parameter int CNT_W      = 12
) (
  input  logic             cmos_pclk_i,
  input  logic             rstn_i,
  input  logic             cmos_href_i,
  input  logic             cmos_vsync_i,
  input  logic [DW-1:0]    cmos_data_i,
  input  logic [1:0]       mode_i,
  input  logic             swap_i,
  input  logic             capture_en_i,
  output logic [23:0]      rgb_o,
  output logic             de_o,
  output logic             vs_o,
  output logic             hs_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic [CNT_W-1:0] width_o,
  output logic [15:0]      frame_cnt_o,
  output logic             line_err_o
);

  localparam int SKW = (FRAME_SKIP < 1) ? 1 : $clog2(FRAME_SKIP + 1);

  logic             href_s1, href_s2, href_s3;
  logic             vs_s1, vs_s2;
  logic [7:0]       data_s1, data_s2;
  logic             vs_rise, href_rise, href_fall, byte_en;

  rx_state_e        state, state_nxt;
  logic [SKW-1:0]   skip_cnt, skip_nxt;
  logic             active;

  pix_mode_e        mode_q;
  logic             swap_q;
  logic [1:0]       phase;
  logic             last_byte;
  logic [CNT_W-1:0] x, y, x_inc, y_inc, x_end;
  logic             first_line;
  logic [23:0]      pix_rgb;
  logic             pix_valid, pix_ok;

  // Input pipeline: two stages for data/vsync, a third href stage for hs_o.
  always_ff @(posedge cmos_pclk_i) begin
    if (!rstn_i) begin
      href_s1 <= 1'b0;
      href_s2 <= 1'b0;
      href_s3 <= 1'b0;
      vs_s1   <= 1'b0;
      vs_s2   <= 1'b0;
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      href_s1 <= cmos_href_i;
      href_s2 <= href_s1;
      href_s3 <= href_s2;
      vs_s1   <= cmos_vsync_i;
      vs_s2   <= vs_s1;
      data_s1 <= cmos_data_i[DW-1 -: 8];
      data_s2 <= data_s1;
    end
  end

  assign vs_rise   = vs_s1 & ~vs_s2;
  assign href_rise = href_s1 & ~href_s2;
  assign href_fall = ~href_s1 & href_s2;
  assign byte_en   = href_s2;

  // FSM: state register
  always_ff @(posedge cmos_pclk_i) begin
    if (!rstn_i) begin
      state    <= ST_SKIP;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  // FSM: next state; capture_en_i is only looked at on a vsync rising edge
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    if (vs_rise) begin
      unique case (state)
        ST_SKIP: begin
          if (skip_cnt == SKW'(FRAME_SKIP))
            state_nxt = capture_en_i ? ST_ACTIVE : ST_HOLD;
          else
            skip_nxt = skip_cnt + SKW'(1);
        end
        default: state_nxt = capture_en_i ? ST_ACTIVE : ST_HOLD;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    active = (state == ST_ACTIVE);
    vs_o   = vs_s2 & active;
    hs_o   = href_s3 & active;
  end

  cmos_rx_pix_pack u_pack (
    .cmos_pclk_i (cmos_pclk_i),
    .rstn_i      (rstn_i),
    .clr_i       (vs_rise),
    .byte_en_i   (byte_en),
    .byte_i      (data_s2),
    .phase_i     (phase),
    .mode_i      (mode_q),
    .swap_i      (swap_q),
    .rgb_o       (pix_rgb),
    .valid_o     (pix_valid)
  );

  assign last_byte = (phase == bytes_per_px(mode_q) - 2'd1);
  assign pix_ok    = pix_valid && active;
  assign x_inc     = (x == '1) ? x : x + 1'b1;
  assign y_inc     = (y == '1) ? y : y + 1'b1;
  // Line length including a pixel that completes on the last byte itself.
  assign x_end     = pix_ok ? x_inc : x;

  always_ff @(posedge cmos_pclk_i) begin
    if (!rstn_i) begin
      mode_q      <= MODE_RAW8;
      swap_q      <= 1'b0;
      phase       <= '0;
      x           <= '0;
      y           <= '0;
      first_line  <= 1'b0;
      width_o     <= '0;
      frame_cnt_o <= '0;
      rgb_o       <= '0;
      de_o        <= 1'b0;
      x_o         <= '0;
      y_o         <= '0;
      line_err_o  <= 1'b0;
    end else begin
      de_o       <= pix_ok;
      line_err_o <= 1'b0;
      if (pix_ok) begin
        rgb_o <= pix_rgb;
        x_o   <= x;
        y_o   <= y;
      end
      if (vs_rise) begin
        mode_q     <= pix_mode_e'(mode_i);
        swap_q     <= swap_i;
        y          <= '0;
        phase      <= '0;
        first_line <= 1'b1;
        if (state_nxt == ST_ACTIVE) frame_cnt_o <= frame_cnt_o + 16'd1;
      end else if (href_rise) begin
        x     <= '0;
        phase <= '0;
      end else if (byte_en) begin
        phase <= last_byte ? 2'd0 : phase + 2'd1;
        if (pix_ok) x <= x_inc;
        // Partial pixel and length mismatch share one pulse.
        if (href_fall) begin
          y <= y_inc;
          if (active) begin
            if (first_line) begin
              width_o    <= x_end;
              first_line <= 1'b0;
            end
            line_err_o <= !last_byte || (!first_line && (x_end != width_o));
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cmos_dvp_rx.sv
module tb_cmos_dvp_rx;

  localparam int DW         = 8;
  localparam int FRAME_SKIP = 5;
  localparam int CNT_W      = 12;

  logic             cmos_pclk_i = 1'b0;
  logic             rstn_i = 1'b0;
  logic             cmos_href_i = 1'b0;
  logic             cmos_vsync_i = 1'b0;
  logic [DW-1:0]    cmos_data_i = '0;
  logic [1:0]       mode_i = '0;
  logic             swap_i = 1'b0;
  logic             capture_en_i = 1'b0;
  logic [23:0]      rgb_o;
  logic             de_o, vs_o, hs_o, line_err_o;
  logic [CNT_W-1:0] x_o, y_o, width_o;
  logic [15:0]      frame_cnt_o;

  cmos_dvp_rx #(.DW(DW), .FRAME_SKIP(FRAME_SKIP), .CNT_W(CNT_W)) dut (
    .cmos_pclk_i  (cmos_pclk_i),
    .rstn_i       (rstn_i),
    .cmos_href_i  (cmos_href_i),
    .cmos_vsync_i (cmos_vsync_i),
    .cmos_data_i  (cmos_data_i),
    .mode_i       (mode_i),
    .swap_i       (swap_i),
    .capture_en_i (capture_en_i),
    .rgb_o        (rgb_o),
    .de_o         (de_o),
    .vs_o         (vs_o),
    .hs_o         (hs_o),
    .x_o          (x_o),
    .y_o          (y_o),
    .width_o      (width_o),
    .frame_cnt_o  (frame_cnt_o),
    .line_err_o   (line_err_o)
  );

  always #5 cmos_pclk_i = ~cmos_pclk_i;

  int cyc = 0;
  always @(posedge cmos_pclk_i) cyc <= cyc + 1;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [23:0] rgb;
    int          x;
    int          y;
    int          c;
  } px_t;

  px_t pq[$];
  int  eq[$];
  int  n_vec = 0;
  int  n_err = 0;

  // Reference model state (frame-level view of the receiver)
  int         m_seen, m_fcnt, m_y, m_width;
  bit         m_active, m_first, m_wvalid, m_swap;
  logic [1:0] m_mode;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int unsigned bpp_of(input logic [1:0] m);
    return (m == 2'd0) ? 1 : (m == 2'd2) ? 3 : 2;
  endfunction

  function automatic logic [23:0] model_px(input logic [1:0] m, input bit sw,
                                           input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
    logic [15:0] w;
    logic [4:0]  r, bl;
    logic [5:0]  g;
    case (m)
      2'd0: return {a, a, a};
      2'd1: begin
        w  = sw ? {b, a} : {a, b};
        r  = w[15:11];
        g  = w[10:5];
        bl = w[4:0];
        return {r, r[4:2], g, g[5:4], bl, bl[4:2]};
      end
      2'd2: return sw ? {c, b, a} : {a, b, c};
      default: return sw ? {b, a, 8'h00} : {a, b, 8'h00};
    endcase
  endfunction

  task automatic model_reset();
    m_seen = 0; m_fcnt = 0; m_y = 0; m_width = 0;
    m_active = 0; m_first = 0; m_wvalid = 0; m_swap = 0; m_mode = 2'd0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rgb"}, rgb_o, 0);
    chk({tag, "_de"}, de_o, 0);
    chk({tag, "_vs"}, vs_o, 0);
    chk({tag, "_hs"}, hs_o, 0);
    chk({tag, "_x"}, x_o, 0);
    chk({tag, "_y"}, y_o, 0);
    chk({tag, "_width"}, width_o, 0);
    chk({tag, "_fcnt"}, frame_cnt_o, 0);
    chk({tag, "_lerr"}, line_err_o, 0);
  endtask

  task automatic do_vsync(input logic [1:0] m, input bit sw, input bit cap);
    @(negedge cmos_pclk_i);
    mode_i = m; swap_i = sw; capture_en_i = cap; cmos_vsync_i = 1'b1;
    repeat (3) @(negedge cmos_pclk_i);
    if (m_seen < FRAME_SKIP) begin
      m_seen++;
      m_active = 0;
    end else begin
      m_active = cap;
      if (cap) m_fcnt = (m_fcnt + 1) & 16'hFFFF;
    end
    m_mode = m; m_swap = sw; m_y = 0; m_first = 1;
    chk("vs_o", vs_o, m_active);
    cmos_vsync_i = 1'b0;
    repeat (4) @(negedge cmos_pclk_i);
  endtask

  task automatic do_line(input bq_t bq);
    int unsigned bpp, ph;
    int          x, last_c;
    bit          err;
    logic [7:0]  g[3];
    px_t         e;
    bpp = bpp_of(m_mode); ph = 0; x = 0; last_c = 0;
    g[0] = 8'h00; g[1] = 8'h00; g[2] = 8'h00;
    for (int i = 0; i < bq.size(); i++) begin
      @(negedge cmos_pclk_i);
      if (i == 3) chk("hs_o", hs_o, m_active);
      cmos_href_i = 1'b1;
      cmos_data_i = bq[i];
      last_c = cyc;
      g[ph] = bq[i];
      if (ph == bpp - 1) begin
        if (m_active) begin
          e.rgb = model_px(m_mode, m_swap, g[0], g[1], g[2]);
          e.x = x; e.y = m_y; e.c = cyc + 3;
          pq.push_back(e);
        end
        x++;
        ph = 0;
      end else ph++;
    end
    @(negedge cmos_pclk_i);
    cmos_href_i = 1'b0;
    cmos_data_i = 8'($urandom);
    if (m_active) begin
      err = (ph != 0);
      if (m_first) begin
        m_width = x; m_wvalid = 1; m_first = 0;
      end else if (x != m_width) err = 1;
      if (err) eq.push_back(last_c + 3);
    end
    m_y++;
    repeat (4) @(negedge cmos_pclk_i);
  endtask

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Mid-frame changes to mode/swap/capture must not affect the latched frame.
  task automatic disturb(input bit cap);
    mode_i = 2'($urandom); swap_i = 1'($urandom); capture_en_i = ~cap;
  endtask

  task automatic end_frame_checks();
    chk("frame_cnt", frame_cnt_o, m_fcnt);
    if (m_active && m_wvalid) chk("width", width_o, m_width);
  endtask

  // Monitor / scoreboard
  initial begin
    px_t e;
    int  ec;
    forever begin
      @(posedge cmos_pclk_i);
      #1;
      if (de_o === 1'b1) begin
        if (pq.size() == 0) chk("de_unexpected", de_o, 0);
        else begin
          e = pq.pop_front();
          chk("rgb", rgb_o, e.rgb);
          chk("x_o", x_o, e.x);
          chk("y_o", y_o, e.y);
          chk("de_cycle", cyc, e.c);
        end
      end
      if (line_err_o === 1'b1) begin
        if (eq.size() == 0) chk("lerr_unexpected", line_err_o, 0);
        else begin
          ec = eq.pop_front();
          chk("lerr_cycle", cyc, ec);
        end
      end
    end
  end

  initial begin
    bq_t        q;
    logic [1:0] m;
    bit         sw, cap;
    int         nl, w, n;
    model_reset();
    repeat (3) @(negedge cmos_pclk_i);
    check_zero("rst");
    rstn_i = 1'b1;

    // Skipped frames carry pixels that must never show up.
    for (int f = 0; f < FRAME_SKIP; f++) begin
      do_vsync(2'd1, 0, 1);
      do_line(rand_bytes(8));
      end_frame_checks();
    end

    // First captured frame: RGB565, 2 lines x 4 px
    do_vsync(2'd1, 0, 1);
    disturb(1);
    q = rand_bytes(6); q.push_front(8'h1F); q.push_front(8'hF8);
    do_line(q);
    do_line(rand_bytes(8));
    end_frame_checks();

    // RGB565 swapped; second line one pixel short
    do_vsync(2'd1, 1, 1);
    disturb(1);
    q = rand_bytes(6); q.push_front(8'h1F); q.push_front(8'hF8);
    do_line(q);
    do_line(rand_bytes(6));
    end_frame_checks();

    // RGB888; second line ends on a partial pixel that also matches width
    do_vsync(2'd2, 0, 1);
    disturb(1);
    q = rand_bytes(3); q.push_front(8'h56); q.push_front(8'h34); q.push_front(8'h12);
    do_line(q);
    do_line(rand_bytes(7));
    end_frame_checks();

    // Capture disabled: no pixels, counter holds
    do_vsync(2'd0, 0, 0);
    disturb(0);
    do_line(rand_bytes(5));
    do_line(rand_bytes(5));
    end_frame_checks();

    // Randomised frames
    for (int f = 0; f < 10; f++) begin
      m = 2'($urandom); sw = 1'($urandom); cap = ($urandom_range(0, 3) != 0);
      do_vsync(m, sw, cap);
      disturb(cap);
      nl = $urandom_range(2, 4);
      w  = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++) begin
        n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : w * bpp_of(m);
        do_line(rand_bytes(n));
      end
      end_frame_checks();
    end

    // Reset in the middle of an RGB888 line with a partial pixel in flight
    do_vsync(2'd2, 0, 1);
    @(negedge cmos_pclk_i); cmos_href_i = 1'b1; cmos_data_i = 8'hAA;
    @(negedge cmos_pclk_i); cmos_data_i = 8'hBB;
    @(negedge cmos_pclk_i); rstn_i = 1'b0; cmos_href_i = 1'b0;
    @(posedge cmos_pclk_i); #1;
    check_zero("midrst");
    @(negedge cmos_pclk_i); rstn_i = 1'b1;
    model_reset();
    for (int f = 0; f < FRAME_SKIP; f++) begin
      do_vsync(2'd0, 0, 1);
      do_line(rand_bytes(4));
      end_frame_checks();
    end
    do_vsync(2'd3, 1, 1);
    do_line(rand_bytes(6));
    do_line(rand_bytes(6));
    end_frame_checks();

    repeat (10) @(negedge cmos_pclk_i);
    chk("pix_queue_empty", pq.size(), 0);
    chk("err_queue_empty", eq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
